// File: rtl/exception_ctrl.sv
// exception_ctrl: exception/interrupt requester feeding the CP0 exception port.
// Gates sync traps (syscall/break/teq) and external IRQs with CP0 status enables,
// prioritises them, issues a one-cycle exception pulse and blocks nesting until eret.
// Optional feature macro: EXC_IRQ_SYNC_EN -- when defined, irq passes through a
// 2-flop synchroniser before edge detection (pin edge -> irq_pend in 3 cycles);
// when undefined, irq is registered once (pin edge -> irq_pend in 2 cycles).
module exception_ctrl #(
  parameter int unsigned NUM_IRQ   = 4,
  parameter logic [4:0]  CAUSE_INT = 5'd0,
  parameter logic [4:0]  CAUSE_SYS = 5'd8,
  parameter logic [4:0]  CAUSE_BRK = 5'd9,
  parameter logic [4:0]  CAUSE_TEQ = 5'd13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [31:0]        pc,
  input  logic               syscall,
  input  logic               brk,
  input  logic               teq_trap,
  input  logic               eret,
  input  logic [31:0]        status,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               exception,
  output logic [4:0]         cause,
  output logic [31:0]        exc_pc,
  output logic [2:0]         irq_id,
  output logic               in_handler,
  output logic [NUM_IRQ-1:0] irq_pend
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAKE    = 2'd1,
    ST_HANDLER = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               exc_q;
  logic               inh_q;
  logic [4:0]         cause_q, cause_d;
  logic [31:0]        pc_q, pc_d;
  logic [2:0]         id_q, id_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] irq_s_q, prev_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] sel_oh, clr;
  logic [2:0]         irq_sel;
  logic               irq_hit;
  logic               gate, sys_ok, brk_ok, teq_ok, int_ok;
  logic               status_unused;

  assign status_unused = ^status[31:5];

`ifdef EXC_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q;

  // Two-flop synchroniser for asynchronous irq pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      irq_s_q <= '0;
    end else begin
      sync1_q <= irq;
      irq_s_q <= sync1_q;
    end
  end
`else
  // Single register stage for synchronous irq sources
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_s_q <= '0;
    else        irq_s_q <= irq;
  end
`endif

  // Previous sampled irq for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= irq_s_q;
  end

  assign rise = irq_s_q & ~prev_q;

  // Lowest-index pending IRQ, as an index and a one-hot clear mask
  always_comb begin
    irq_sel = '0;
    irq_hit = 1'b0;
    sel_oh  = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (pend_q[i] && !irq_hit) begin
        irq_hit   = 1'b1;
        irq_sel   = 3'(i);
        sel_oh[i] = 1'b1;
      end
    end
  end

  assign gate   = instr_valid & status[0];
  assign sys_ok = gate & syscall  & status[1];
  assign brk_ok = gate & brk      & status[2];
  assign teq_ok = gate & teq_trap & status[3];
  assign int_ok = gate & irq_hit  & status[4];

  // Next-state, request prioritisation and latch values for the take
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    id_d    = id_q;
    clr     = '0;
    case (state_q)
      ST_IDLE: begin
        if (sys_ok || brk_ok || teq_ok || int_ok) begin
          state_d = ST_TAKE;
          pc_d    = pc;
          id_d    = '0;
          if (sys_ok)      cause_d = CAUSE_SYS;
          else if (brk_ok) cause_d = CAUSE_BRK;
          else if (teq_ok) cause_d = CAUSE_TEQ;
          else begin
            cause_d = CAUSE_INT;
            id_d    = irq_sel;
            clr     = sel_oh;
          end
        end
      end
      ST_TAKE:    state_d = ST_HANDLER;
      ST_HANDLER: if (instr_valid && eret) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A fresh edge on the line being taken re-sets its bit (OR applied after clear)
  assign pend_d = (pend_q & ~clr) | rise;

  // State, registered pulse/handler flag, held cause/pc/id, pending IRQs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      exc_q   <= 1'b0;
      inh_q   <= 1'b0;
      cause_q <= '0;
      pc_q    <= '0;
      id_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      exc_q   <= (state_d == ST_TAKE);
      inh_q   <= (state_d != ST_IDLE);
      cause_q <= cause_d;
      pc_q    <= pc_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
    end
  end

  assign exception  = exc_q;
  assign in_handler = inh_q;
  assign cause      = cause_q;
  assign exc_pc     = pc_q;
  assign irq_id     = id_q;
  assign irq_pend   = pend_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl; pend latency follows EXC_IRQ_SYNC_EN.
module tb_exception_ctrl;

`ifdef EXC_IRQ_SYNC_EN
  localparam int PEND_LAT = 3;
`else
  localparam int PEND_LAT = 2;
`endif

  logic        clk, rst_n, instr_valid, syscall, brk, teq_trap, eret;
  logic [31:0] pc, status;
  logic [3:0]  irq;
  logic        exception, in_handler;
  logic [4:0]  cause;
  logic [31:0] exc_pc;
  logic [2:0]  irq_id;
  logic [3:0]  irq_pend;

  int n_chk = 0;
  int n_bad = 0;

  exception_ctrl #(.NUM_IRQ(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .pc         (pc),
    .syscall    (syscall),
    .brk        (brk),
    .teq_trap   (teq_trap),
    .eret       (eret),
    .status     (status),
    .irq        (irq),
    .exception  (exception),
    .cause      (cause),
    .exc_pc     (exc_pc),
    .irq_id     (irq_id),
    .in_handler (in_handler),
    .irq_pend   (irq_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 0; rst_n = 0; instr_valid = 0; pc = '0; syscall = 0; brk = 0;
    teq_trap = 0; eret = 0; status = 32'h1F; irq = '0;
    tick();
    chk("rst_exc", exception, 0);
    chk("rst_inh", in_handler, 0);
    chk("rst_pend", irq_pend, 0);
    chk("rst_cause", cause, 0);
    chk("rst_pc", exc_pc, 0);
    chk("rst_id", irq_id, 0);
    rst_n = 1;
    tick();

    // eret in IDLE has no effect
    instr_valid = 1; eret = 1; tick();
    chk("idle_eret_exc", exception, 0);
    chk("idle_eret_inh", in_handler, 0);
    eret = 0; instr_valid = 0;

    // T1: syscall
    instr_valid = 1; syscall = 1; pc = 32'h0040_0010; tick();
    chk("t1_exc", exception, 1);
    chk("t1_cause", cause, 8);
    chk("t1_pc", exc_pc, 32'h0040_0010);
    chk("t1_id", irq_id, 0);
    chk("t1_inh", in_handler, 1);
    syscall = 0; instr_valid = 0; pc = '0; tick();
    chk("t1_pulse_end", exception, 0);
    chk("t1_inh_hold", in_handler, 1);
    chk("t1_cause_hold", cause, 8);
    instr_valid = 1; eret = 1; tick();
    chk("t1_eret_inh", in_handler, 0);
    eret = 0; instr_valid = 0;

    // T2: two IRQs rise together, lowest wins; check pend latency
    irq = 4'b0110;
    for (int k = 1; k < PEND_LAT; k++) begin
      tick();
      chk("t2_pend_early", irq_pend, 0);
    end
    tick();
    chk("t2_pend_lat", irq_pend, 4'b0110);
    instr_valid = 1; pc = 32'h100; tick();
    chk("t2_exc", exception, 1);
    chk("t2_cause", cause, 0);
    chk("t2_id", irq_id, 1);
    chk("t2_pc", exc_pc, 32'h100);
    chk("t2_pend", irq_pend, 4'b0100);
    instr_valid = 0; tick();
    instr_valid = 1; eret = 1; tick();
    eret = 0; pc = 32'h104; tick();
    chk("t2b_exc", exception, 1);
    chk("t2b_id", irq_id, 2);
    chk("t2b_pend", irq_pend, 0);
    instr_valid = 0; tick();

    // T3: requests ignored in HANDLER, pending still captured
    instr_valid = 1; brk = 1; tick();
    chk("t3_brk_exc", exception, 0);
    chk("t3_brk_inh", in_handler, 1);
    brk = 0; instr_valid = 0;
    irq = 4'b1110;
    repeat (PEND_LAT) tick();
    chk("t3_pend", irq_pend, 4'b1000);
    chk("t3_noexc", exception, 0);
    instr_valid = 1; eret = 1; tick();
    chk("t3_eret_inh", in_handler, 0);
    chk("t3_eret_exc", exception, 0);
    eret = 0; pc = 32'h200; tick();
    chk("t3_irq3_exc", exception, 1);
    chk("t3_irq3_id", irq_id, 3);
    chk("t3_irq3_cause", cause, 0);
    chk("t3_irq3_pc", exc_pc, 32'h200);
    chk("t3_irq3_pend", irq_pend, 0);
    instr_valid = 0; tick();

    // eret and brk together in HANDLER: eret wins, brk re-evaluated in IDLE
    instr_valid = 1; eret = 1; brk = 1; tick();
    chk("erwin_exc", exception, 0);
    chk("erwin_inh", in_handler, 0);
    eret = 0; pc = 32'h300; tick();
    chk("erwin_brk_exc", exception, 1);
    chk("erwin_brk_cause", cause, 9);
    chk("erwin_brk_pc", exc_pc, 32'h300);
    brk = 0; instr_valid = 0; tick();
    instr_valid = 1; eret = 1; tick();
    eret = 0; instr_valid = 0;

    // T4: disabled syscall dropped; IE=0 drops; IRQ0 taken alongside masked syscall
    status = 32'h1D; instr_valid = 1; syscall = 1; tick();
    chk("t4_sysdis_exc", exception, 0);
    chk("t4_sysdis_inh", in_handler, 0);
    status = 32'h1E; tick();
    chk("t4_ie0_exc", exception, 0);
    syscall = 0; instr_valid = 0; status = 32'h1D; tick();
    chk("t4_nodefer", exception, 0);
    irq = 4'b1111;
    repeat (PEND_LAT) tick();
    chk("t4_pend", irq_pend, 4'b0001);
    instr_valid = 1; syscall = 1; pc = 32'h400; tick();
    chk("t4_exc", exception, 1);
    chk("t4_cause", cause, 0);
    chk("t4_id", irq_id, 0);
    chk("t4_pend_clr", irq_pend, 0);
    syscall = 0; instr_valid = 0; tick();
    instr_valid = 1; eret = 1; tick();
    eret = 0; instr_valid = 0; status = 32'h1F;

    // T5: masked IRQ stays pending; sync trap beats pending IRQ
    irq = '0;
    repeat (PEND_LAT + 1) tick();
    irq = 4'b0010;
    repeat (PEND_LAT) tick();
    chk("t5_pend", irq_pend, 4'b0010);
    status = 32'h0F; instr_valid = 1; tick();
    chk("t5_mask_exc", exception, 0);
    chk("t5_mask_pend", irq_pend, 4'b0010);
    status = 32'h1F; syscall = 1; teq_trap = 1; pc = 32'h500; tick();
    chk("t5_exc", exception, 1);
    chk("t5_cause", cause, 8);
    chk("t5_id", irq_id, 0);
    chk("t5_pend", irq_pend, 4'b0010);
    syscall = 0; teq_trap = 0; instr_valid = 0; irq = '0; tick();
    chk("t5_inh", in_handler, 1);

    // T6: async reset mid-HANDLER
    rst_n = 0; #1;
    chk("t6_inh", in_handler, 0);
    chk("t6_exc", exception, 0);
    chk("t6_pend", irq_pend, 0);
    chk("t6_cause", cause, 0);
    tick();
    rst_n = 1; tick();
    chk("t6_post_exc", exception, 0);
    chk("t6_post_pend", irq_pend, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
